core_lsu: RTL and testbench
===========================

Name: core_lsu

Overview:
Parametrised load/store unit for the memory stage of the RV32IMF pipeline. It drives the req/gnt/rvalid data-memory interface and keeps up to MAX_OUTSTANDING loads in flight. It generates byte enables, replicates store data, and aligns and sign-extends returned load data. It raises stall_o toward the pipeline and flags misaligned accesses and protocol errors.

Parameters:
DATA_WIDTH, 32, data bus and register width (fixed 32 for byte-lane logic)
ADDR_WIDTH, 16, data memory address width driven on data_addr_o
REG_ADDR_WIDTH, 5, register-file address width
MAX_OUTSTANDING, 2, maximum granted-but-unreturned loads (power of 2, >=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m_data_rd_i  in  1  load request from memory stage
m_data_wr_i  in  1  store request from memory stage
m_data_addr_i  in  DATA_WIDTH  byte address
m_wdata_i  in  DATA_WIDTH  store data, right-aligned
m_size_i  in  2  0=byte, 1=half, 2=word
m_unsigned_i  in  1  load zero-extends when 1
m_regfile_waddr_i  in  REG_ADDR_WIDTH  load destination register
m_FP_OP_i  in  1  load targets FP register file
stall_general_i  in  1  global pipeline freeze
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_wr_o  out  1  1=write
data_addr_o  out  ADDR_WIDTH  word-aligned address (low 2 bits forced 0)
data_be_o  out  4  byte enables
data_wdata_o  out  DATA_WIDTH  lane-replicated store data
data_rdata_i  in  DATA_WIDTH  read data
data_rvalid_i  in  1  read data valid
stall_o  out  1  hold memory stage
w_load_valid_o  out  1  one-cycle writeback strobe
w_load_waddr_o  out  REG_ADDR_WIDTH  writeback register
w_load_data_o  out  DATA_WIDTH  formatted load data
w_load_fp_o  out  1  writeback goes to FP file
misaligned_o  out  1  one-cycle misaligned-access pulse
protocol_err_o  out  1  sticky: rvalid seen with no load outstanding

Behaviour:
- Reset: all outputs 0; FIFO empty; count 0; protocol_err_o cleared. Reset mid-operation drops in-flight metadata; later rvalids set protocol_err_o.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Result: no request, misaligned_o=1 for that cycle, no stall.
- data_req_o = (rd|wr) & aligned & !stall_general_i & !(rd & count==MAX_OUTSTANDING). Address, be, wdata and wr are combinational from m_* inputs and held stable while req=1 and gnt=0.
- data_be_o: byte=1<<a[1:0]; half=0011/1100 by a[1]; word=1111. data_wdata_o: byte replicated x4, half x2, word as-is.
- Acceptance: req&gnt in a cycle. An accepted load pushes {waddr, a[1:0], size, unsigned, fp} into the metadata FIFO (depth MAX_OUTSTANDING). Stores push nothing.
- stall_o = (data_req_o & !data_gnt_i) | ((rd|wr) & aligned & rd & count==MAX_OUTSTANDING & !stall_general_i). stall_o is 0 on the accept cycle.
- Return: rvalid with FIFO non-empty pops the head. The next cycle w_load_valid_o=1 with registered waddr/fp and data = rdata shifted right by 8*offset, then masked to size and sign- or zero-extended. Returns are never back-pressured and are processed regardless of stall_general_i.
- Simultaneous push and pop: count unchanged; a pop frees a slot combinationally for the same-cycle request (full & rvalid permits accept).
- rvalid with FIFO empty: ignored, protocol_err_o=1 until reset.
- Ordering: responses are strictly in request order. Stores may be granted while loads are outstanding.

Decomposition:
- Shared defines: size encodings, DATA_WIDTH, MEM_ADDR_WIDTH, REG_ADDR_WIDTH.
- One sub-module: core_lsu_fifo, a parametrised synchronous FIFO holding load metadata, with full/empty/count outputs and pointer wrap-around.

Test Plan:
- Reset, then LB addr 0x0003, gnt immediately, rvalid next cycle rdata 0x80FF_FF12 -> w_load_data_o=0xFFFF_FF80, w_load_valid_o one cycle after rvalid, be=1000.
- SH addr 0x0002, wdata 0x0000_ABCD, gnt delayed 3 cycles -> stall_o=1 for 3 cycles, be=1100, data_wdata_o=0xABCD_ABCD, held stable until gnt.
- MAX_OUTSTANDING=2: three back-to-back LW with gnt=1, rvalid withheld -> third request blocked, stall_o=1; rvalid on the same cycle as the third request -> accepted that cycle, count stays 2.
- LW addr 0x0001 -> misaligned_o pulse, data_req_o=0, stall_o=0.
- rvalid with no load outstanding -> protocol_err_o=1 and sticky; assert rst_n low with two loads outstanding -> FIFO cleared, a subsequent rvalid sets protocol_err_o.
- LHU addr 0x0002, rdata 0x8765_0000 -> w_load_data_o=0x0000_8765; m_FP_OP_i=1 on LW -> w_load_fp_o=1.

Source files
------------

// File: rtl/core_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - default bus/address/register widths
//   - access size encodings
//   - alignment check and load-data formatting helpers
package core_lsu_pkg;

  localparam int LSU_DATA_WIDTH     = 32;
  localparam int LSU_MEM_ADDR_WIDTH = 16;
  localparam int LSU_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } lsu_size_e;

  // Size code 3 is handled like a word everywhere in the unit.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~off[0];
      default:   ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  // Move the addressed lane down to bit 0, then trim to the access size
  // and extend according to the signedness of the load.
  function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      SIZE_BYTE: res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_HALF: res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:   res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/core_lsu_fifo.sv
// Synchronous FIFO holding metadata of loads that were granted but whose
// data has not yet returned.
//   clk, rst_n      clock, async active-low reset (empties the FIFO)
//   push, wdata     write an entry; accepted when not full or when a pop
//                   happens in the same cycle
//   pop, rdata      rdata shows the head; pop removes it when non-empty
//   full, empty     occupancy flags
//   count           number of stored entries
module core_lsu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // A same-cycle pop frees the slot the push is about to use.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_lsu.sv
// Memory-stage load/store unit driving a req/gnt/rvalid data interface.
//   m_*                 access request from the memory stage
//   stall_general_i     global freeze; blocks new requests only
//   data_*              data-memory interface (word-aligned address,
//                       byte enables, lane-replicated store data)
//   stall_o             hold the memory stage (waiting for grant or slot)
//   w_load_*            registered writeback of returned load data
//   misaligned_o        misaligned access presented this cycle
//   protocol_err_o      sticky: rvalid arrived with no load outstanding
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int DATA_WIDTH      = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH      = LSU_MEM_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH  = LSU_REG_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_data_rd_i,
  input  logic                      m_data_wr_i,
  input  logic [DATA_WIDTH-1:0]     m_data_addr_i,
  input  logic [DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [1:0]                m_size_i,
  input  logic                      m_unsigned_i,
  input  logic [REG_ADDR_WIDTH-1:0] m_regfile_waddr_i,
  input  logic                      m_FP_OP_i,
  input  logic                      stall_general_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic                      data_wr_o,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_rvalid_i,
  output logic                      stall_o,
  output logic                      w_load_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] w_load_waddr_o,
  output logic [DATA_WIDTH-1:0]     w_load_data_o,
  output logic                      w_load_fp_o,
  output logic                      misaligned_o,
  output logic                      protocol_err_o
);

  // metadata entry: {waddr, offset[1:0], size[1:0], unsigned, fp}
  localparam int META_W = REG_ADDR_WIDTH + 6;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic              access, aligned, is_load, limit_block;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [META_W-1:0] push_meta, head_meta;
  logic              unused_bits;

  assign access  = m_data_rd_i | m_data_wr_i;
  assign is_load = m_data_rd_i & ~m_data_wr_i;
  assign aligned = is_aligned(m_size_i, m_data_addr_i[1:0]);

  // A full FIFO only blocks a load when no return frees a slot this cycle.
  assign limit_block = m_data_rd_i & fifo_full & ~data_rvalid_i;

  assign data_req_o   = access & aligned & ~stall_general_i & ~limit_block;
  assign stall_o      = (data_req_o & ~data_gnt_i) |
                        (access & aligned & limit_block & ~stall_general_i);
  assign misaligned_o = access & ~aligned;

  assign data_wr_o   = m_data_wr_i;
  assign data_addr_o = {m_data_addr_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = m_wdata_i;
    case (m_size_i)
      SIZE_BYTE: begin
        data_be_o    = 4'b0001 << m_data_addr_i[1:0];
        data_wdata_o = {4{m_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        data_be_o    = m_data_addr_i[1] ? 4'b1100 : 4'b0011;
        data_wdata_o = {2{m_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign push      = data_req_o & data_gnt_i & is_load;
  assign pop       = data_rvalid_i & ~fifo_empty;
  assign push_meta = {m_regfile_waddr_i, m_data_addr_i[1:0], m_size_i,
                      m_unsigned_i, m_FP_OP_i};

  core_lsu_fifo #(
    .WIDTH (META_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_meta),
    .pop   (pop),
    .rdata (head_meta),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Upper byte-address bits lie outside the data memory; count is only
  // informative here since full/empty carry the decisions.
  assign unused_bits = ^{fifo_count, m_data_addr_i[DATA_WIDTH-1:ADDR_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_load_valid_o <= 1'b0;
      w_load_waddr_o <= '0;
      w_load_data_o  <= '0;
      w_load_fp_o    <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      w_load_valid_o <= pop;
      if (pop) begin
        w_load_waddr_o <= head_meta[META_W-1:6];
        w_load_data_o  <= format_load(data_rdata_i, head_meta[5:4],
                                      head_meta[3:2], head_meta[1]);
        w_load_fp_o    <= head_meta[0];
      end
      if (data_rvalid_i & fifo_empty) protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_data_rd_i, m_data_wr_i;
  logic [31:0] m_data_addr_i, m_wdata_i;
  logic [1:0]  m_size_i;
  logic        m_unsigned_i;
  logic [4:0]  m_regfile_waddr_i;
  logic        m_FP_OP_i, stall_general_i;
  logic        data_req_o, data_gnt_i, data_wr_o;
  logic [15:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o, data_rdata_i;
  logic        data_rvalid_i, stall_o;
  logic        w_load_valid_o;
  logic [4:0]  w_load_waddr_o;
  logic [31:0] w_load_data_o;
  logic        w_load_fp_o, misaligned_o, protocol_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m_data_rd_i       (m_data_rd_i),
    .m_data_wr_i       (m_data_wr_i),
    .m_data_addr_i     (m_data_addr_i),
    .m_wdata_i         (m_wdata_i),
    .m_size_i          (m_size_i),
    .m_unsigned_i      (m_unsigned_i),
    .m_regfile_waddr_i (m_regfile_waddr_i),
    .m_FP_OP_i         (m_FP_OP_i),
    .stall_general_i   (stall_general_i),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_wr_o         (data_wr_o),
    .data_addr_o       (data_addr_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_rdata_i      (data_rdata_i),
    .data_rvalid_i     (data_rvalid_i),
    .stall_o           (stall_o),
    .w_load_valid_o    (w_load_valid_o),
    .w_load_waddr_o    (w_load_waddr_o),
    .w_load_data_o     (w_load_data_o),
    .w_load_fp_o       (w_load_fp_o),
    .misaligned_o      (misaligned_o),
    .protocol_err_o    (protocol_err_o)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        gnt, sg;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [15:0] e_addr;
    logic        e_stall, e_mis;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    m_data_rd_i = 0; m_data_wr_i = 0; m_data_addr_i = 0; m_wdata_i = 0;
    m_size_i = 0; m_unsigned_i = 0; m_regfile_waddr_i = 0; m_FP_OP_i = 0;
    stall_general_i = 0; data_gnt_i = 0; data_rdata_i = 0; data_rvalid_i = 0;
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    m_data_rd_i = rd; m_data_wr_i = wr; m_size_i = size;
    m_data_addr_i = addr; m_wdata_i = wdata;
  endtask

  // Single load granted at once, data returned the following cycle.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic fp, input logic [4:0] waddr,
                         input logic [31:0] rdata, input logic sg_on_return,
                         input logic [31:0] exp_data);
    @(negedge clk);
    set_acc(1, 0, size, addr, 0);
    m_unsigned_i = uns; m_FP_OP_i = fp; m_regfile_waddr_i = waddr; data_gnt_i = 1;
    #1 chk({name, "_req"}, data_req_o, 1);
    chk({name, "_stall"}, stall_o, 0);
    @(negedge clk);
    idle();
    data_rvalid_i = 1; data_rdata_i = rdata; stall_general_i = sg_on_return;
    #1 chk({name, "_wb_early"}, w_load_valid_o, 0);
    @(negedge clk);
    idle();
    #1 chk({name, "_wb_valid"}, w_load_valid_o, 1);
    chk({name, "_wb_data"}, w_load_data_o, exp_data);
    chk({name, "_wb_waddr"}, w_load_waddr_o, waddr);
    chk({name, "_wb_fp"}, w_load_fp_o, fp);
    @(negedge clk);
    #1 chk({name, "_wb_once"}, w_load_valid_o, 0);
  endtask

  initial begin
    //        name        rd wr sz addr          wdata         g  sg  req be       wdata         addr      st mis
    vecs[0] = '{"sb_off1",  0, 1, 0, 32'h00000001, 32'h12345678, 1, 0, 1, 4'b0010, 32'h78787878, 16'h0000, 0, 0};
    vecs[1] = '{"sb_off2",  0, 1, 0, 32'h00000106, 32'h000000AB, 1, 0, 1, 4'b0100, 32'hABABABAB, 16'h0104, 0, 0};
    vecs[2] = '{"sh_lo",    0, 1, 1, 32'h00002000, 32'h0000BEEF, 1, 0, 1, 4'b0011, 32'hBEEFBEEF, 16'h2000, 0, 0};
    vecs[3] = '{"sh_mis",   0, 1, 1, 32'h00000003, 32'h00001234, 1, 0, 0, 4'b1100, 32'h12341234, 16'h0000, 0, 1};
    vecs[4] = '{"sw",       0, 1, 2, 32'h00000010, 32'hDEADBEEF, 1, 0, 1, 4'b1111, 32'hDEADBEEF, 16'h0010, 0, 0};
    vecs[5] = '{"sw_mis",   0, 1, 2, 32'h00000012, 32'hCAFEF00D, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 16'h0010, 0, 1};
    vecs[6] = '{"lw_mis",   1, 0, 2, 32'h00000001, 32'h00000000, 1, 0, 0, 4'b1111, 32'h00000000, 16'h0000, 0, 1};
    vecs[7] = '{"sb_frz",   0, 1, 0, 32'hFFFF0007, 32'h0000005A, 1, 1, 0, 4'b1000, 32'h5A5A5A5A, 16'h0004, 0, 0};
    vecs[8] = '{"lb_nognt", 1, 0, 0, 32'h00000005, 32'h00000000, 0, 0, 1, 4'b0010, 32'h00000000, 16'h0004, 1, 0};
    vecs[9] = '{"sw_nognt", 0, 1, 2, 32'h00000008, 32'h01020304, 0, 0, 1, 4'b1111, 32'h01020304, 16'h0008, 1, 0};

    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rst_wb_valid", w_load_valid_o, 0);
    chk("rst_perr", protocol_err_o, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wdata", w_load_data_o, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      set_acc(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      data_gnt_i = vecs[i].gnt; stall_general_i = vecs[i].sg;
      #1;
      chk({vecs[i].name, "_req"},   data_req_o,   vecs[i].e_req);
      chk({vecs[i].name, "_be"},    data_be_o,    vecs[i].e_be);
      chk({vecs[i].name, "_wdata"}, data_wdata_o, vecs[i].e_wdata);
      chk({vecs[i].name, "_addr"},  data_addr_o,  vecs[i].e_addr);
      chk({vecs[i].name, "_stall"}, stall_o,      vecs[i].e_stall);
      chk({vecs[i].name, "_mis"},   misaligned_o, vecs[i].e_mis);
      chk({vecs[i].name, "_wr"},    data_wr_o,    vecs[i].wr);
    end
    @(negedge clk);
    idle();
    #1 chk("mis_pulse_end", misaligned_o, 0);
    chk("table_no_wb", w_load_valid_o, 0);

    // LB from the top byte, sign-extended.
    do_load("lb3", 32'h00000003, 2'd0, 0, 0, 5'd7, 32'h80FFFF12, 0, 32'hFFFFFF80);

    // SH with the grant arriving after three waiting cycles.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      set_acc(0, 1, 2'd1, 32'h00000002, 32'h0000ABCD);
      data_gnt_i = (c == 3);
      #1 chk($sformatf("sh_wait%0d_stall", c), stall_o, (c != 3));
      chk($sformatf("sh_wait%0d_req", c), data_req_o, 1);
      chk($sformatf("sh_wait%0d_be", c), data_be_o, 4'b1100);
      chk($sformatf("sh_wait%0d_wdata", c), data_wdata_o, 32'hABCDABCD);
      chk($sformatf("sh_wait%0d_addr", c), data_addr_o, 16'h0000);
    end

    // The store pushed nothing, so an rvalid now is a protocol error.
    @(negedge clk);
    idle();
    data_rvalid_i = 1; data_rdata_i = 32'h5555AAAA;
    #1 chk("perr_before", protocol_err_o, 0);
    @(negedge clk);
    idle();
    #1 chk("perr_set", protocol_err_o, 1);
    chk("perr_no_wb", w_load_valid_o, 0);
    @(negedge clk);
    #1 chk("perr_sticky", protocol_err_o, 1);

    // Two loads fill the FIFO; the third waits until a return frees a slot.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      set_acc(1, 0, 2'd2, 32'h00000100 + 32'(4 * c), 0);
      m_regfile_waddr_i = 5'(c + 1); data_gnt_i = 1;
      #1 chk($sformatf("lw%0d_req", c + 1), data_req_o, 1);
      chk($sformatf("lw%0d_stall", c + 1), stall_o, 0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      set_acc(1, 0, 2'd2, 32'h00000108, 0);
      m_regfile_waddr_i = 5'd3; m_FP_OP_i = 1; data_gnt_i = 1;
      #1 chk($sformatf("lw3_full%0d_req", c), data_req_o, 0);
      chk($sformatf("lw3_full%0d_stall", c), stall_o, 1);
    end
    @(negedge clk);
    data_rvalid_i = 1; data_rdata_i = 32'h11111111;
    #1 chk("lw3_pop_req", data_req_o, 1);
    chk("lw3_pop_stall", stall_o, 0);
    @(negedge clk);
    idle();
    set_acc(1, 0, 2'd2, 32'h0000010C, 0);
    data_gnt_i = 1;
    #1 chk("lw4_still_full_stall", stall_o, 1);
    chk("lw4_still_full_req", data_req_o, 0);
    chk("ret1_valid", w_load_valid_o, 1);
    chk("ret1_waddr", w_load_waddr_o, 5'd1);
    chk("ret1_data", w_load_data_o, 32'h11111111);
    chk("ret1_fp", w_load_fp_o, 0);
    @(negedge clk);
    idle();
    data_rvalid_i = 1; data_rdata_i = 32'h22222222;
    #1 chk("ret1_once", w_load_valid_o, 0);
    @(negedge clk);
    data_rdata_i = 32'h33333333;
    #1 chk("ret2_waddr", w_load_waddr_o, 5'd2);
    chk("ret2_data", w_load_data_o, 32'h22222222);
    chk("ret2_fp", w_load_fp_o, 0);
    @(negedge clk);
    idle();
    #1 chk("ret3_valid", w_load_valid_o, 1);
    chk("ret3_waddr", w_load_waddr_o, 5'd3);
    chk("ret3_data", w_load_data_o, 32'h33333333);
    chk("ret3_fp", w_load_fp_o, 1);

    // Halfword/byte formatting; one return arrives under a global freeze.
    do_load("lhu2", 32'h00000002, 2'd1, 1, 0, 5'd9, 32'h87650000, 0, 32'h00008765);
    do_load("lh2", 32'h00000002, 2'd1, 0, 0, 5'd10, 32'h87650000, 1, 32'hFFFF8765);
    do_load("lbu1", 32'h00000001, 2'd0, 1, 0, 5'd11, 32'h0000A500, 0, 32'h000000A5);
    do_load("lwfp", 32'h00000020, 2'd2, 0, 1, 5'd12, 32'h3F800000, 0, 32'h3F800000);

    // Reset with two loads in flight drops their metadata.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      set_acc(1, 0, 2'd2, 32'h00000040, 0);
      data_gnt_i = 1;
    end
    @(negedge clk);
    idle();
    rst_n = 0;
    #1 chk("rst2_perr_clr", protocol_err_o, 0);
    chk("rst2_wb", w_load_valid_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    data_rvalid_i = 1; data_rdata_i = 32'h12345678;
    @(negedge clk);
    idle();
    #1 chk("rst2_perr_set", protocol_err_o, 1);
    chk("rst2_no_wb", w_load_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
